// File: rtl/s10scfifo_ext.sv
// Single-clock FIFO, FIFOF-style guards, showahead or registered read, level flags, sticky errors.
// Latency: write visible 1 cycle after accept; mode 0 q valid 1 cycle after accepted read.
// Backpressure: wrfull_n/rdempty_n guard; rejected writes when full set overflow, reads when empty set underflow.
module s10scfifo_ext #(
  parameter int WIDTH        = 1,
  parameter int DEPTH        = 16,
  parameter int SHOWAHEAD    = 1,
  parameter int ALMOST_FULL  = DEPTH - 2,
  parameter int ALMOST_EMPTY = 2
) (
  input  logic                     clk,
  input  logic                     aclr,
  input  logic                     sclr,
  input  logic [WIDTH-1:0]         data,
  input  logic                     wrreq,
  input  logic                     rdreq,
  output logic [WIDTH-1:0]         q,
  output logic                     rdempty_n,
  output logic                     wrfull_n,
  output logic [$clog2(DEPTH):0]   usedw,
  output logic                     almost_full,
  output logic                     almost_empty,
  output logic                     overflow,
  output logic                     underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int UW = AW + 1;
  localparam logic [UW-1:0] LP_DEPTH = UW'(DEPTH);
  localparam logic [UW-1:0] LP_AF    = UW'(ALMOST_FULL);
  localparam logic [UW-1:0] LP_AE    = UW'(ALMOST_EMPTY);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [UW-1:0]    r_usedw;
  logic [UW-1:0]    w_usedw_nxt;
  logic             r_ready;
  logic             r_rdempty_n;
  logic             r_wrfull_n;
  logic             r_af;
  logic             r_ae;
  logic             r_ovf;
  logic             r_unf;
  logic             w_wr_acc;
  logic             w_rd_acc;

  // sclr masks both requests; the registered guards alone decide acceptance
  assign w_wr_acc = !sclr && wrreq && r_wrfull_n;
  assign w_rd_acc = !sclr && rdreq && r_rdempty_n;

  // Next occupancy: shared by the counter and all registered level flags
  always_comb begin
    w_usedw_nxt = r_usedw;
    if (sclr) begin
      w_usedw_nxt = '0;
    end else begin
      case ({w_wr_acc, w_rd_acc})
        2'b10:   w_usedw_nxt = r_usedw + UW'(1);
        2'b01:   w_usedw_nxt = r_usedw - UW'(1);
        default: w_usedw_nxt = r_usedw;
      endcase
    end
  end

  // Storage array; contents are don't-care until written, so no reset
  always_ff @(posedge clk) begin
    if (w_wr_acc) begin
      r_mem[r_wptr] <= data;
    end
  end

  // Pointers, occupancy, guards, level flags and sticky error flags
  always_ff @(posedge clk or posedge aclr) begin
    if (aclr) begin
      r_ready     <= 1'b0;
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_usedw     <= '0;
      r_rdempty_n <= 1'b0;
      r_wrfull_n  <= 1'b0;
      r_af        <= 1'b0;
      r_ae        <= 1'b1;
      r_ovf       <= 1'b0;
      r_unf       <= 1'b0;
    end else begin
      // ready goes high on the first edge after aclr and stays; wrfull_n follows it
      r_ready     <= 1'b1;
      r_usedw     <= w_usedw_nxt;
      r_rdempty_n <= (w_usedw_nxt != '0);
      r_wrfull_n  <= (w_usedw_nxt != LP_DEPTH);
      r_af        <= (w_usedw_nxt >= LP_AF);
      r_ae        <= (w_usedw_nxt <= LP_AE);
      if (sclr) begin
        r_wptr <= '0;
        r_rptr <= '0;
        r_ovf  <= 1'b0;
        r_unf  <= 1'b0;
      end else begin
        if (w_wr_acc) r_wptr <= r_wptr + AW'(1);
        if (w_rd_acc) r_rptr <= r_rptr + AW'(1);
        // drops while not ready see usedw==0, so they never flag overflow
        if (wrreq && (r_usedw == LP_DEPTH)) r_ovf <= 1'b1;
        if (rdreq && !r_rdempty_n)          r_unf <= 1'b1;
      end
    end
  end

  generate
    if (SHOWAHEAD != 0) begin : g_showahead
      // Head entry falls through from storage, forced to zero while empty
      assign q = r_rdempty_n ? r_mem[r_rptr] : '0;
    end else begin : g_normal
      logic [WIDTH-1:0] r_q;
      // Registered read port: loads the head on an accepted read, else holds
      always_ff @(posedge clk or posedge aclr) begin
        if (aclr) begin
          r_q <= '0;
        end else if (sclr) begin
          r_q <= '0;
        end else if (w_rd_acc) begin
          r_q <= r_mem[r_rptr];
        end
      end
      assign q = r_q;
    end
  endgenerate

  assign rdempty_n    = r_rdempty_n;
  assign wrfull_n     = r_wrfull_n;
  assign usedw        = r_usedw;
  assign almost_full  = r_af;
  assign almost_empty = r_ae;
  assign overflow     = r_ovf;
  assign underflow    = r_unf;

endmodule

// File: tb/tb_s10scfifo_ext.sv
// Testbench for s10scfifo_ext: one showahead and one registered-read instance share stimulus.
// Queue-based reference model; outputs sampled on the falling edge.
// Inputs change on the falling edge, so each rising edge sees stable requests.
module tb_s10scfifo_ext;
  localparam int W  = 8;
  localparam int D  = 16;
  localparam int AF = 14;
  localparam int AE = 2;

  logic clk = 1'b0;
  logic aclr, sclr, wrreq, rdreq;
  logic [W-1:0] data;

  logic [W-1:0] sa_q, nr_q;
  logic [4:0]   sa_usedw, nr_usedw;
  logic sa_ne, sa_nf, sa_af, sa_ae, sa_ovf, sa_unf;
  logic nr_ne, nr_nf, nr_af, nr_ae, nr_ovf, nr_unf;

  int n_checks = 0;
  int n_fail   = 0;

  // reference model state
  logic [W-1:0] mq[$];
  bit           m_ready, m_ovf, m_unf;
  logic [W-1:0] m_q0;

  always #5 clk = ~clk;

  s10scfifo_ext #(.WIDTH(W), .DEPTH(D), .SHOWAHEAD(1), .ALMOST_FULL(AF), .ALMOST_EMPTY(AE)) u_sa (
    .clk(clk), .aclr(aclr), .sclr(sclr), .data(data), .wrreq(wrreq), .rdreq(rdreq),
    .q(sa_q), .rdempty_n(sa_ne), .wrfull_n(sa_nf), .usedw(sa_usedw),
    .almost_full(sa_af), .almost_empty(sa_ae), .overflow(sa_ovf), .underflow(sa_unf));

  s10scfifo_ext #(.WIDTH(W), .DEPTH(D), .SHOWAHEAD(0), .ALMOST_FULL(AF), .ALMOST_EMPTY(AE)) u_nr (
    .clk(clk), .aclr(aclr), .sclr(sclr), .data(data), .wrreq(wrreq), .rdreq(rdreq),
    .q(nr_q), .rdempty_n(nr_ne), .wrfull_n(nr_nf), .usedw(nr_usedw),
    .almost_full(nr_af), .almost_empty(nr_ae), .overflow(nr_ovf), .underflow(nr_unf));

  task automatic model_reset();
    mq.delete();
    m_ready = 0;
    m_ovf   = 0;
    m_unf   = 0;
    m_q0    = '0;
  endtask

  // one rising edge of the specified behaviour, applied to a plain queue
  task automatic model_step(input bit w, input bit r, input logic [W-1:0] d, input bit s);
    bit empty, wr_ok, rd_ok;
    if (s) begin
      mq.delete();
      m_ovf = 0;
      m_unf = 0;
      m_q0  = '0;
    end else begin
      empty = (mq.size() == 0);
      wr_ok = w && m_ready && (mq.size() < D);
      rd_ok = r && !empty;
      if (w && mq.size() == D) m_ovf = 1;
      if (r && empty)          m_unf = 1;
      if (rd_ok) m_q0 = mq.pop_front();
      if (wr_ok) mq.push_back(d);
    end
    m_ready = 1;
  endtask

  function automatic logic [37:0] exp_vec();
    logic [4:0]  u;
    logic [10:0] f;
    u = 5'(mq.size());
    f = {u, u != 0, m_ready && (mq.size() < D), mq.size() >= AF, mq.size() <= AE, m_ovf, m_unf};
    return {f, f, (u != 0) ? mq[0] : 8'h00, m_q0};
  endfunction

  function automatic logic [37:0] act_vec();
    return {sa_usedw, sa_ne, sa_nf, sa_af, sa_ae, sa_ovf, sa_unf,
            nr_usedw, nr_ne, nr_nf, nr_af, nr_ae, nr_ovf, nr_unf, sa_q, nr_q};
  endfunction

  // drive one cycle of requests, advance the model on the edge, return at the falling edge
  task automatic tick(input bit w, input bit r, input logic [W-1:0] d, input bit s);
    wrreq = w; rdreq = r; data = d; sclr = s;
    @(posedge clk);
    model_step(w, r, d, s);
    @(negedge clk);
    wrreq = 0; rdreq = 0; sclr = 0;
  endtask

  task automatic test_reset();
    aclr = 1; sclr = 0; wrreq = 0; rdreq = 0; data = '0;
    model_reset();
    repeat (2) @(negedge clk);
    n_checks++;
    if (act_vec() !== exp_vec()) begin
      n_fail++; $display("FAIL reset_state act=%h exp=%h", act_vec(), exp_vec());
    end
    n_checks++;
    if ({sa_nf, sa_ae, sa_usedw} !== {1'b0, 1'b1, 5'd0}) begin
      n_fail++; $display("FAIL reset_const act=%b exp=%b", {sa_nf, sa_ae, sa_usedw}, {1'b0, 1'b1, 5'd0});
    end
    aclr = 0;
    tick(1, 0, 8'h11, 0);
    n_checks++;
    if ({sa_usedw, sa_ovf} !== {5'd0, 1'b0}) begin
      n_fail++; $display("FAIL ready_drop usedw=%0d ovf=%b exp 0/0", sa_usedw, sa_ovf);
    end
    tick(1, 0, 8'h22, 0);
    n_checks++;
    if ({sa_usedw, sa_q} !== {5'd1, 8'h22}) begin
      n_fail++; $display("FAIL ready_accept usedw=%0d q=%h exp 1/22", sa_usedw, sa_q);
    end
  endtask

  task automatic test_fill_wrap();
    tick(0, 0, 0, 1);
    for (int i = 0; i < D; i++) begin
      tick(1, 0, 8'(i), 0);
      n_checks++;
      if ({sa_usedw, sa_af} !== {5'(i + 1), (i + 1) >= AF}) begin
        n_fail++; $display("FAIL fill_af[%0d] usedw=%0d af=%b", i, sa_usedw, sa_af);
      end
    end
    n_checks++;
    if (sa_nf !== 1'b0) begin
      n_fail++; $display("FAIL full_guard wrfull_n=%b exp 0", sa_nf);
    end
    tick(1, 0, 8'hEE, 0);
    n_checks++;
    if ({sa_usedw, sa_ovf, nr_ovf} !== {5'd16, 1'b1, 1'b1}) begin
      n_fail++; $display("FAIL overflow usedw=%0d ovf=%b/%b exp 16/1/1", sa_usedw, sa_ovf, nr_ovf);
    end
    for (int i = 0; i < D; i++) begin
      n_checks++;
      if (sa_q !== 8'(i)) begin
        n_fail++; $display("FAIL drain_sa[%0d] q=%h exp %h", i, sa_q, 8'(i));
      end
      tick(0, 1, 0, 0);
      n_checks++;
      if (nr_q !== 8'(i)) begin
        n_fail++; $display("FAIL drain_nr[%0d] q=%h exp %h", i, nr_q, 8'(i));
      end
    end
    for (int i = 0; i < 40; i++) begin
      tick(1, $urandom_range(0, 1) == 1, 8'($urandom), 0);
      n_checks++;
      if (act_vec() !== exp_vec()) begin
        n_fail++; $display("FAIL wrap_wr[%0d] act=%h exp=%h", i, act_vec(), exp_vec());
      end
    end
    for (int i = 0; i < 24; i++) begin
      tick(0, 1, 0, 0);
      n_checks++;
      if (act_vec() !== exp_vec()) begin
        n_fail++; $display("FAIL wrap_rd[%0d] act=%h exp=%h", i, act_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_simultaneous();
    tick(0, 0, 0, 1);
    for (int i = 0; i < 5; i++) tick(1, 0, 8'(8'h30 + i), 0);
    for (int i = 0; i < 10; i++) begin
      tick(1, 1, 8'($urandom), 0);
      n_checks++;
      if (sa_usedw !== 5'd5 || act_vec() !== exp_vec()) begin
        n_fail++; $display("FAIL simul[%0d] act=%h exp=%h", i, act_vec(), exp_vec());
      end
    end
    tick(0, 0, 0, 1);
    tick(1, 1, 8'h77, 0);
    n_checks++;
    if ({sa_usedw, sa_unf, sa_q} !== {5'd1, 1'b1, 8'h77}) begin
      n_fail++; $display("FAIL empty_simul usedw=%0d unf=%b q=%h exp 1/1/77", sa_usedw, sa_unf, sa_q);
    end
  endtask

  task automatic test_modes();
    tick(0, 0, 0, 1);
    tick(1, 0, 8'hA5, 0);
    n_checks++;
    if ({sa_q, nr_q} !== {8'hA5, 8'h00}) begin
      n_fail++; $display("FAIL mode_write sa_q=%h nr_q=%h exp a5/00", sa_q, nr_q);
    end
    tick(0, 0, 0, 0);
    n_checks++;
    if (nr_q !== 8'h00) begin
      n_fail++; $display("FAIL mode0_hold q=%h exp 00", nr_q);
    end
    tick(0, 1, 0, 0);
    n_checks++;
    if ({sa_q, nr_q} !== {8'h00, 8'hA5}) begin
      n_fail++; $display("FAIL mode_read sa_q=%h nr_q=%h exp 00/a5", sa_q, nr_q);
    end
  endtask

  task automatic test_sclr();
    tick(0, 0, 0, 1);
    for (int i = 0; i < D + 1; i++) tick(1, 0, 8'(i), 0);
    for (int i = 0; i < 9; i++)     tick(0, 1, 0, 0);
    n_checks++;
    if ({sa_usedw, sa_ovf} !== {5'd7, 1'b1}) begin
      n_fail++; $display("FAIL sclr_setup usedw=%0d ovf=%b exp 7/1", sa_usedw, sa_ovf);
    end
    tick(1, 0, 8'h55, 1);
    n_checks++;
    if ({sa_usedw, sa_ne, sa_ovf, nr_q} !== {5'd0, 1'b0, 1'b0, 8'h00}) begin
      n_fail++; $display("FAIL sclr_clear usedw=%0d ne=%b ovf=%b nr_q=%h exp 0/0/0/00", sa_usedw, sa_ne, sa_ovf, nr_q);
    end
    tick(0, 0, 0, 0);
    n_checks++;
    if (act_vec() !== exp_vec()) begin
      n_fail++; $display("FAIL sclr_after act=%h exp=%h", act_vec(), exp_vec());
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      tick($urandom_range(0, 99) < 55, $urandom_range(0, 99) < 50, 8'($urandom),
           $urandom_range(0, 99) == 0);
      n_checks++;
      if (act_vec() !== exp_vec()) begin
        n_fail++; $display("FAIL random[%0d] act=%h exp=%h", i, act_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_aclr_mid();
    for (int i = 0; i < 6; i++) tick(1, 0, 8'($urandom), 0);
    aclr = 1;
    #1;
    model_reset();
    n_checks++;
    if ({sa_usedw, sa_ne, sa_nf, nr_usedw} !== {5'd0, 1'b0, 1'b0, 5'd0}) begin
      n_fail++; $display("FAIL aclr_async usedw=%0d ne=%b nf=%b exp 0/0/0", sa_usedw, sa_ne, sa_nf);
    end
    @(negedge clk);
    aclr = 0;
    tick(0, 0, 0, 0);
    n_checks++;
    if (sa_nf !== 1'b1 || act_vec() !== exp_vec()) begin
      n_fail++; $display("FAIL aclr_release act=%h exp=%h", act_vec(), exp_vec());
    end
  endtask

  initial begin
    test_reset();
    test_fill_wrap();
    test_simultaneous();
    test_modes();
    test_sclr();
    test_random();
    test_aclr_mid();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/s10scfifo_ext.md
# s10scfifo_ext

Parametrised single-clock FIFO for Stratix 10 datapaths, the next generation of the team's dual-clock dcfifo wrapper. It keeps the Bluespec FIFOF-style interface: `rdempty_n` and `wrfull_n` serve as the guards, and `q` is the head value. It adds a choice of showahead or normal read mode, a fill-level count, programmable almost-full and almost-empty flags, synchronous clear, and sticky overflow/underflow flags. It is used wherever producer and consumer share one clock, for example SerialLite III packet staging after the clock crossing.

## Interface
- `WIDTH`, 1: data width in bits.
- `DEPTH`, 16: number of entries; must be a power of 2 and ≥ 2.
- `SHOWAHEAD`, 1: 1 = first-word-fall-through, 0 = normal registered read.
- `ALMOST_FULL`, DEPTH-2: `almost_full` threshold, range 1..DEPTH.
- `ALMOST_EMPTY`, 2: `almost_empty` threshold, range 0..DEPTH-1.
- `UW` (localparam): clog2(DEPTH)+1.

Ports:
- `clk`  in  1: single clock; all logic is rising-edge.
- `aclr`  in  1: asynchronous, active-high reset.
- `sclr`  in  1: synchronous clear.
- `data`  in  WIDTH: write data.
- `wrreq`  in  1: enqueue request.
- `rdreq`  in  1: dequeue request.
- `q`  out  WIDTH: head data.
- `rdempty_n`  out  1: FIFO is non-empty.
- `wrfull_n`  out  1: FIFO can accept a write.
- `usedw`  out  UW: occupancy, 0..DEPTH.
- `almost_full`  out  1: usedw ≥ ALMOST_FULL.
- `almost_empty`  out  1: usedw ≤ ALMOST_EMPTY.
- `overflow`  out  1: sticky flag; a write was attempted while full.
- `underflow`  out  1: sticky flag; a read was attempted while empty.

## Operation
- Storage is DEPTH×WIDTH. The write and read pointers are clog2(DEPTH) bits wide and wrap naturally (DEPTH-1 → 0). `usedw` is an explicit UW-bit counter.
- **Write acceptance:** a write is accepted iff `wrreq && wrfull_n`. The accepted write stores `data` at the write pointer and increments the pointer.
- **Read acceptance:** a read is accepted iff `rdreq && rdempty_n`. The accepted read increments the read pointer.
- **Simultaneous accepted read and write:** `usedw` is unchanged and both pointers advance. When full, a simultaneous `rdreq` does not allow a write in the same cycle; `wrfull_n` is the only write guard.
- **Empty with wrreq and rdreq together:** the write is accepted. The read is rejected and counts as underflow.
- **Overflow:** `wrreq && usedw==DEPTH` sets `overflow`, and the data is dropped. `underflow` is set by `rdreq && !rdempty_n`. Both flags hold until `sclr` or `aclr`.
- **Startup state:** an internal `ready` register resets to 0 and is set on the first `clk` edge after `aclr` deasserts. `wrfull_n = ready && usedw<DEPTH`. A `wrreq` while `ready=0` is dropped silently and does not set `overflow`.
- **SHOWAHEAD=1:** `q` presents the entry at the read pointer whenever `rdempty_n=1`, and `q=0` when empty. An accepted read makes the next entry visible on the following cycle.
- **SHOWAHEAD=0:** `q` is a register. On an accepted read, `q` loads the entry at the read pointer, visible on the next cycle. Otherwise `q` holds its value.
- **sclr:** highest priority. It zeroes both pointers, `usedw`, `overflow`, `underflow` and (in mode 0) `q`. A `wrreq`/`rdreq` in the same cycle is ignored. `ready` is unaffected.
- **Flags:** `almost_full` and `almost_empty` are registered and computed from the next `usedw`, so they change on the same edge as `usedw`.

## Timing
- **Reset values (aclr=1):** q=0, rdempty_n=0, wrfull_n=0, usedw=0, almost_full=0 (1 if ALMOST_FULL=0 is ever allowed; it is not), almost_empty=1, overflow=0, underflow=0.
- **Write-to-read latency:** 1 cycle. A write on edge N gives rdempty_n=1 and usedw=1 after edge N. In mode 1, q is valid after the same edge.
- **Mode 0 read latency:** 1 cycle from accepted rdreq to q valid.
- All outputs are registered except q in mode 1 (read from storage, gated by rdempty_n).
- **Full throughput:** one write and one read per cycle sustained, at any occupancy from 1 to DEPTH-1.
- **aclr mid-operation:** all state is lost immediately and the contents are discarded. wrfull_n returns to 1 one edge after deassertion.

## Test plan
- **Reset/ready:** assert aclr, release it, and drive wrreq=1 on the first edge → write dropped, usedw=0, overflow=0. On the second edge the write is accepted, and usedw=1.
- **Fill/wrap (DEPTH=16, ALMOST_FULL=14):** write 0..15 → almost_full=1 at usedw=14, wrfull_n=0 at 16. A 17th wrreq sets overflow=1 and usedw stays 16. Read 16 entries → values 0..15 in order. Then write/read 40 more entries to exercise pointer wrap.
- **Simultaneous:** with usedw=5, drive wrreq and rdreq together for 10 cycles → usedw stays 5 and data order is preserved. With the FIFO empty, drive both together → usedw=1, underflow=1.
- **Modes:** in SHOWAHEAD=1, write 0xA5 → q=0xA5 the next cycle without rdreq. In SHOWAHEAD=0, q stays 0 until rdreq and shows 0xA5 one cycle after it.
- **sclr:** with usedw=7, overflow=1, and sclr asserted together with wrreq → after the edge, usedw=0, rdempty_n=0, overflow=0, and the write is discarded.
